// File: rtl/packet_output_scheduler.sv
// Round-robin, packet-granular scheduler draining three FWFT port FIFOs onto one 8-bit link.
// Holds each grant until the CRC byte is popped; a stall watchdog aborts a dry mid-packet grant.
module packet_output_scheduler #(
  parameter logic [7:0] STALL_MAX = 8'd255
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic [2:0] port_en,
  input  logic       rempty_port_1,
  input  logic       rempty_port_2,
  input  logic       rempty_port_3,
  input  logic [7:0] rdata_port_1,
  input  logic [7:0] rdata_port_2,
  input  logic [7:0] rdata_port_3,
  output logic       rinc_port_1,
  output logic       rinc_port_2,
  output logic       rinc_port_3,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_port,
  output logic       busy,
  output logic       pkt_done,
  output logic       stall_err
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t     state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic [1:0] last_grant, last_grant_nxt;
  logic [3:0] byte_cnt, byte_cnt_nxt;
  logic [3:0] pkt_len, pkt_len_nxt;
  logic [7:0] stall_cnt, stall_cnt_nxt;
  logic [2:0] req;
  logic [1:0] cand;
  logic       rempty_g;
  logic [7:0] rdata_g;
  logic       pop, last, abort;

  always_comb begin
    req = port_en & ~{rempty_port_3, rempty_port_2, rempty_port_1};
    rempty_g = 1'b1;
    rdata_g  = '0;
    unique case (grant)
      2'd1:    begin rempty_g = rempty_port_1; rdata_g = rdata_port_1; end
      2'd2:    begin rempty_g = rempty_port_2; rdata_g = rdata_port_2; end
      2'd3:    begin rempty_g = rempty_port_3; rdata_g = rdata_port_3; end
      default: begin rempty_g = 1'b1;          rdata_g = '0;           end
    endcase
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    byte_cnt_nxt   = byte_cnt;
    pkt_len_nxt    = pkt_len;
    stall_cnt_nxt  = stall_cnt;
    pop            = 1'b0;
    last           = 1'b0;
    abort          = 1'b0;
    cand           = last_grant;
    unique case (state)
      IDLE: begin
        // Walk the ports starting after the previous winner, wrapping 3 -> 1.
        for (int unsigned k = 0; k < 3; k++) begin
          cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
          if (state_nxt == IDLE && req[cand - 2'd1]) begin
            grant_nxt = cand;
            state_nxt = XFER;
          end
        end
      end
      XFER: begin
        pop = !rempty_g && (!out_valid || out_ready);
        if (pop) begin
          byte_cnt_nxt  = byte_cnt + 4'd1;
          stall_cnt_nxt = '0;
          if (byte_cnt == 4'd2) pkt_len_nxt = {1'b0, rdata_g[2:0]} + 4'd4;
          if (byte_cnt >= 4'd3 && byte_cnt == pkt_len - 4'd1) begin
            last           = 1'b1;
            last_grant_nxt = grant;
            byte_cnt_nxt   = '0;
            state_nxt      = IDLE;
          end
        end else if (rempty_g) begin
          if (stall_cnt == STALL_MAX - 8'd1) begin
            abort          = 1'b1;
            last_grant_nxt = grant;
            byte_cnt_nxt   = '0;
            stall_cnt_nxt  = '0;
            state_nxt      = IDLE;
          end else begin
            stall_cnt_nxt = stall_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 2'd3;
      byte_cnt   <= '0;
      pkt_len    <= '0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      byte_cnt   <= byte_cnt_nxt;
      pkt_len    <= pkt_len_nxt;
      stall_cnt  <= stall_cnt_nxt;
    end
  end

  // Output stage: one byte deep, contents frozen while the link back-pressures.
  always_ff @(posedge clk1) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_port  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= rdata_g;
      out_sop   <= (byte_cnt == 4'd0);
      out_eop   <= last;
      out_port  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign rinc_port_1 = pop && (grant == 2'd1);
  assign rinc_port_2 = pop && (grant == 2'd2);
  assign rinc_port_3 = pop && (grant == 2'd3);
  assign busy        = (state == XFER);
  assign pkt_done    = last;
  assign stall_err   = abort;

endmodule

// File: tb/tb_packet_output_scheduler.sv
// Bench for packet_output_scheduler: FWFT FIFO models feed the DUT, a packet-level round-robin
// model predicts the output byte stream, and a separate monitor scoreboards every accepted byte.
module tb_packet_output_scheduler;
  localparam logic [7:0] STALL = 8'd8;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] port_en = '0;
  logic       rempty_port_1 = 1'b1, rempty_port_2 = 1'b1, rempty_port_3 = 1'b1;
  logic [7:0] rdata_port_1 = '0, rdata_port_2 = '0, rdata_port_3 = '0;
  logic       rinc_port_1, rinc_port_2, rinc_port_3;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop, out_eop;
  logic [1:0] out_port;
  logic       busy, pkt_done, stall_err;

  always #5 clk1 = ~clk1;

  packet_output_scheduler #(.STALL_MAX(STALL)) dut (
    .clk1(clk1), .rst(rst), .port_en(port_en),
    .rempty_port_1(rempty_port_1), .rempty_port_2(rempty_port_2), .rempty_port_3(rempty_port_3),
    .rdata_port_1(rdata_port_1), .rdata_port_2(rdata_port_2), .rdata_port_3(rdata_port_3),
    .rinc_port_1(rinc_port_1), .rinc_port_2(rinc_port_2), .rinc_port_3(rinc_port_3),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_port(out_port), .busy(busy), .pkt_done(pkt_done),
    .stall_err(stall_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  fifo[3][$];
  logic [7:0]  mbytes[3][$];
  int unsigned mlen[3][$];
  int unsigned model_last = 3;
  int unsigned exp_pkts, exp_bytes;

  int          checks = 0;
  int          failures = 0;
  int unsigned cycle = 0;
  int unsigned rinc_cnt[3] = '{0, 0, 0};
  int unsigned last_pop_cyc[3] = '{0, 0, 0};
  int unsigned done_cnt = 0;
  int unsigned stall_evt = 0;
  int unsigned stall_cyc = 0;
  int unsigned pop_cyc_q[$];
  int unsigned pop_port_q[$];
  int          ready_mode = 0;
  int unsigned ready_ph = 0;
  bit          in_reset = 1'b0;

  // FIFO environment: pops requested in one cycle take effect at the next falling edge.
  always @(negedge clk1) begin
    logic [2:0] rinc, emp;
    logic       pend[3];
    cycle++;
    for (int i = 0; i < 3; i++) begin
      if (pend[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      pend[i] = 1'b0;
    end
    rempty_port_1 = (fifo[0].size() == 0);
    rempty_port_2 = (fifo[1].size() == 0);
    rempty_port_3 = (fifo[2].size() == 0);
    rdata_port_1  = rempty_port_1 ? 8'h00 : fifo[0][0];
    rdata_port_2  = rempty_port_2 ? 8'h00 : fifo[1][0];
    rdata_port_3  = rempty_port_3 ? 8'h00 : fifo[2][0];
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (ready_ph == 0);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    ready_ph = (ready_ph + 1) % 3;
    #1;
    rinc = {rinc_port_3, rinc_port_2, rinc_port_1};
    emp  = {rempty_port_3, rempty_port_2, rempty_port_1};
    for (int i = 0; i < 3; i++) begin
      if (rinc[i]) begin
        pend[i] = 1'b1;
        rinc_cnt[i]++;
        last_pop_cyc[i] = cycle;
        pop_cyc_q.push_back(cycle);
        pop_port_q.push_back(i + 1);
        checks++;
        if (emp[i]) begin
          failures++;
          $display("FAIL pop_empty port=%0d cycle=%0d rinc=1 while rempty=1 (required no pop)", i + 1, cycle);
        end
      end
    end
    if (pkt_done) done_cnt++;
    if (stall_err) begin
      stall_evt++;
      stall_cyc = cycle;
    end
  end

  // Monitor: compares every byte the link accepts and checks hold stability under back-pressure.
  always @(negedge clk1) begin
    exp_t e, cur;
    exp_t held;
    bit   hold_chk;
    #2;
    cur = {out_data, out_sop, out_eop, out_port};
    if (in_reset) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        checks++;
        if (!out_valid || cur != held) begin
          failures++;
          $display("FAIL hold valid=%0d data=%02h sop=%0d eop=%0d port=%0d required valid=1 data=%02h sop=%0d eop=%0d port=%0d",
                   out_valid, cur.data, cur.sop, cur.eop, cur.port, held.data, held.sop, held.eop, held.port);
        end
      end
      hold_chk = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte data=%02h port=%0d required no byte", cur.data, cur.port);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            failures++;
            $display("FAIL scoreboard data=%02h sop=%0d eop=%0d port=%0d required data=%02h sop=%0d eop=%0d port=%0d",
                     cur.data, cur.sop, cur.eop, cur.port, e.data, e.sop, e.eop, e.port);
          end
        end
      end else if (out_valid) begin
        held     = cur;
        hold_chk = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      fifo[i].delete();
      mbytes[i].delete();
      mlen[i].delete();
    end
    exp_q.delete();
    model_last = 3;
    check("reset_outputs",
          {out_valid, out_data, out_sop, out_eop, out_port, busy, pkt_done, stall_err,
           rinc_port_1, rinc_port_2, rinc_port_3}, 0);
    rst = 1'b0;
    tick();
    in_reset = 1'b0;
  endtask

  task automatic load_raw(input int unsigned p, input logic [7:0] b[$]);
    foreach (b[i]) begin
      fifo[p].push_back(b[i]);
      mbytes[p].push_back(b[i]);
    end
    mlen[p].push_back(b.size());
  endtask

  task automatic load_rand(input int unsigned p, input int unsigned sz);
    logic [7:0] b[$];
    b.push_back(8'($urandom));
    b.push_back(8'($urandom));
    b.push_back({5'($urandom), 3'(sz)});
    repeat (sz) b.push_back(8'($urandom));
    b.push_back(8'($urandom));
    load_raw(p, b);
  endtask

  // Packet-level round robin over enabled ports holding complete packets.
  task automatic issue(input logic [2:0] en);
    int unsigned lg;
    bit          found;
    exp_t        e;
    lg = model_last;
    exp_pkts = 0;
    exp_bytes = 0;
    do begin
      found = 1'b0;
      for (int unsigned k = 1; k <= 3 && !found; k++) begin
        int unsigned c, n;
        c = ((lg - 1 + k) % 3) + 1;
        if (en[c-1] && mlen[c-1].size() > 0) begin
          n = mlen[c-1].pop_front();
          for (int unsigned j = 0; j < n; j++) begin
            e.data = mbytes[c-1].pop_front();
            e.sop  = (j == 0);
            e.eop  = (j == n - 1);
            e.port = 2'(c);
            exp_q.push_back(e);
          end
          lg = c;
          found = 1'b1;
          exp_pkts++;
          exp_bytes += n;
        end
      end
    end while (found);
    model_last = lg;
    port_en = en;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    port_en = '0;
  endtask

  task automatic run_round(input logic [2:0] en, input string name);
    int unsigned d0, r0;
    d0 = done_cnt;
    r0 = rinc_cnt[0] + rinc_cnt[1] + rinc_cnt[2];
    issue(en);
    drain(name);
    check({name, "_pkt_done"}, done_cnt - d0, exp_pkts);
    check({name, "_pops"}, rinc_cnt[0] + rinc_cnt[1] + rinc_cnt[2] - r0, exp_bytes);
  endtask

  initial begin
    logic [7:0]  t1[$];
    int unsigned base, r2, n, bad, sc0, d0;
    exp_t        e;

    do_reset();

    // Single 6-byte packet on port 2.
    t1 = '{8'h00, 8'h90, 8'h02, 8'hAA, 8'hBB, 8'hC5};
    r2 = rinc_cnt[1];
    load_raw(1, t1);
    run_round(3'b111, "single");
    check("single_rinc2", rinc_cnt[1] - r2, 6);

    // Three 4-byte packets after reset: order 1,2,3 with exactly one idle cycle between packets.
    do_reset();
    for (int unsigned p = 0; p < 3; p++) load_rand(p, 0);
    base = pop_cyc_q.size();
    run_round(3'b111, "rr3");
    check("rr3_pop_count", pop_cyc_q.size() - base, 12);
    if (pop_cyc_q.size() == base + 12) begin
      bad = 0;
      for (int unsigned i = 0; i < 12; i++)
        if (bad == 0 && pop_port_q[base+i] != i / 4 + 1) bad = i + 1;
      check("rr3_order_first_bad_index_plus1", bad, 0);
      bad = 0;
      for (int unsigned i = 1; i < 12; i++)
        if (bad == 0 && pop_cyc_q[base+i] - pop_cyc_q[base+i-1] != ((i % 4 == 0) ? 2 : 1)) bad = i;
      check("rr3_gap_first_bad_index", bad, 0);
    end

    // 11-byte packet under 1,0,0 back-pressure.
    ready_mode = 1;
    r2 = rinc_cnt[0];
    load_rand(0, 7);
    run_round(3'b111, "bp");
    check("bp_rinc1", rinc_cnt[0] - r2, 11);
    ready_mode = 0;

    // Watchdog: port 3 delivers 3 bytes then runs dry; port 1 becomes pending during the stall.
    sc0 = stall_evt;
    d0  = done_cnt;
    r2  = rinc_cnt[2];
    t1 = '{8'h00, 8'h11, 8'h02};
    foreach (t1[i]) begin
      fifo[2].push_back(t1[i]);
      e.data = t1[i];
      e.sop  = (i == 0);
      e.eop  = 1'b0;
      e.port = 2'd3;
      exp_q.push_back(e);
    end
    port_en = 3'b111;
    n = 0;
    while (rinc_cnt[2] - r2 < 3 && n < 50) begin tick(); n++; end
    check("stall_first_bytes", rinc_cnt[2] - r2, 3);
    load_rand(0, 1);
    n = 0;
    while (stall_evt == sc0 && n < 50) begin tick(); n++; end
    check("stall_err_count", stall_evt - sc0, 1);
    check("stall_err_delay", stall_cyc - last_pop_cyc[2], STALL);
    model_last = 3;
    issue(3'b111);
    drain("stall");
    check("stall_pkt_done", done_cnt - d0, 1);
    check("stall_port3_pops", rinc_cnt[2] - r2, 3);

    // Port 2 disabled: only ports 1 and 3 alternate, then port 2 drains once enabled.
    for (int unsigned p = 0; p < 3; p++) begin
      load_rand(p, $urandom_range(0, 7));
      load_rand(p, $urandom_range(0, 7));
    end
    r2 = rinc_cnt[1];
    run_round(3'b101, "en101");
    check("en101_rinc2", rinc_cnt[1] - r2, 0);
    run_round(3'b111, "en111");

    // Reset mid-packet on port 2, then ports 1 and 2 both pending: port 1 goes first.
    r2 = rinc_cnt[1];
    load_rand(1, 7);
    issue(3'b111);
    n = 0;
    while (rinc_cnt[1] - r2 < 4 && n < 50) begin tick(); n++; end
    check("midrst_progress", (rinc_cnt[1] - r2 >= 4) ? 1 : 0, 1);
    do_reset();
    load_rand(0, 2);
    load_rand(1, 3);
    run_round(3'b111, "postrst");

    // Randomised rounds with random enables and random back-pressure.
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int unsigned p = 0; p < 3; p++)
        repeat ($urandom_range(0, 2)) load_rand(p, $urandom_range(0, 7));
      run_round(3'($urandom_range(1, 7)), "rand");
    end
    run_round(3'b111, "rand_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

endmodule
